// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Sequencing controller for the ID/EX pipeline stage. It watches the decode
// stage and the ID/EX register outputs for three events and converts them into
// write-enable / bubble controls for PC, IF/ID and ID/EX:
//   * load-use hazard   -> one-cycle stall with a single ID/EX bubble
//   * taken branch/jump -> FLUSH_CYCLES cycles of IF/ID flush + ID/EX bubble
//   * data memory busy  -> whole pipe holds until the memory is ready
//
// Parameters
//   FLUSH_CYCLES  number of flush/bubble cycles per taken branch, counting the
//                 detection cycle (legal range 1..15)
//
// Ports
//   clk           clock, state and counters update on the rising edge
//   reset         asynchronous active-high reset
//   id_rs/id_rt   source register fields of the instruction in ID
//   id_uses_rt    ID instruction really reads rt
//   ex_memread    ID/EX holds a load
//   ex_rt         destination register of that load
//   branch_taken  branch/jump resolved taken this cycle
//   mem_busy      data memory not ready, everything must freeze
//   pc_write      PC write enable
//   ifid_write    IF/ID write enable
//   ifid_flush    IF/ID loads a NOP
//   idex_write    ID/EX write enable
//   idex_bubble   ID/EX control inputs forced to zero
//   state_out     current state: 0 RUN, 1 LU_STALL, 2 FLUSH, 3 HOLD
//
// Optional feature (macro HAZARD_CTRL_STATS_EN)
//   stall_cnt     saturating count of load-use bubble cycles
//   flush_cnt     saturating count of branch-caused bubble cycles
//   hold_cnt      saturating count of cycles in which the pipe is held
//
// All controls are combinational from the registered state and the inputs.
// The ID/EX register samples on the falling edge; the inputs of this block
// are registered upstream, so the controls are settled well before then.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       branch_taken,
   input  logic       mem_busy,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_write,
   output logic       idex_bubble,
   output logic [1:0] state_out
`ifdef HAZARD_CTRL_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic [15:0] hold_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_HOLD     = 2'd3
   } state_t;

   // Remaining FLUSH-state cycles loaded on a taken branch; the detection
   // cycle itself is the first of the FLUSH_CYCLES bubbles.
   localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
   localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

   state_t     state_reg;
   state_t     state_next;
   logic [3:0] cnt_reg;
   logic [3:0] cnt_next;
   logic [3:0] cnt_dec;
   logic       lu_hit;

   // Load-use: the load in EX writes a register the ID instruction reads.
   // Register 0 is hard-wired, so a load to r0 never creates a dependency.
   assign lu_hit = ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Saturating decrement keeps a corrupted zero count from wrapping to 15.
   assign cnt_dec = (cnt_reg == 4'd0) ? 4'd0 : (cnt_reg - 4'd1);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_RUN;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // --------------------------------------------------------------------------
   // Next state and controls
   // --------------------------------------------------------------------------
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_next  = state_reg;
      cnt_next    = cnt_reg;

      case (state_reg)
         ST_RUN, ST_LU_STALL: begin
            if (branch_taken) begin
               // PC keeps writing so it picks up the branch target.
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (FLUSH_MULTI) begin
                  state_next = ST_FLUSH;
                  cnt_next   = FLUSH_LOAD;
               end else begin
                  state_next = ST_RUN;
                  cnt_next   = 4'd0;
               end
            end else if (mem_busy) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_write = 1'b0;
               state_next = ST_HOLD;
            end else if (lu_hit && (state_reg == ST_RUN)) begin
               // In LU_STALL the load has already moved on, so a hazard seen
               // there would only be the stale copy and is masked.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               state_next  = ST_LU_STALL;
            end else begin
               state_next = ST_RUN;
            end
         end

         ST_FLUSH: begin
            // Anything arriving now comes from the wrong path, so branch_taken
            // and mem_busy are not looked at.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_next    = cnt_dec;
            if (cnt_dec == 4'd0) begin
               state_next = ST_RUN;
            end
         end

         ST_HOLD: begin
            // EX is frozen and will re-present any branch after the hold, so
            // branch_taken is ignored here. The first ready cycle resumes
            // with default controls.
            if (mem_busy) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_write = 1'b0;
            end else begin
               state_next = ST_RUN;
            end
         end

         default: begin
            state_next = ST_RUN;
            cnt_next   = 4'd0;
         end
      endcase
   end

   assign state_out = state_reg;

`ifdef HAZARD_CTRL_STATS_EN
   // --------------------------------------------------------------------------
   // Statistics. Events are recovered from the controls themselves:
   //   branch bubble : bubble together with an IF/ID flush
   //   load-use      : bubble without a flush
   //   hold          : only a hold ever drops idex_write
   // --------------------------------------------------------------------------
   logic [2:0] stat_inc;

   assign stat_inc[0] = idex_bubble & ~ifid_flush;
   assign stat_inc[1] = idex_bubble &  ifid_flush;
   assign stat_inc[2] = ~idex_write;

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] stat_reg;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stat_reg <= 16'd0;
         end else if (stat_inc[gi] && (stat_reg != 16'hFFFF)) begin
            stat_reg <= stat_reg + 16'd1;
         end
      end
   end

   assign stall_cnt = g_stat[0].stat_reg;
   assign flush_cnt = g_stat[1].stat_reg;
   assign hold_cnt  = g_stat[2].stat_reg;
`endif

endmodule
